mux_8to1: RTL and testbench
===========================

// Module: mux_8to1
// PURPOSE
//  8:1 data selector. A 3-bit select {A,B,C} (A = MSB) chooses one of D0..D7 and drives it onto F.
//  F is purely combinational. F_q is a registered copy for timing-critical consumers.
//  Used as a leaf datapath element wherever the design selects one of eight same-width sources.
// PARAMETERS
//  WIDTH      1   bit width of each data input and of F / F_q
//  RESET_VAL  0   value loaded into F_q while rst is high (WIDTH bits)
// PORTS
//  clk   input   1      single clock; F_q updates on the rising edge
//  rst   input   1      asynchronous, active-high reset (affects F_q only)
//  F     output  WIDTH  selected data, combinational
//  D0    input   WIDTH  data input, selected when {A,B,C} = 3'b000
//  D1    input   WIDTH  data input, selected when {A,B,C} = 3'b001
//  D2    input   WIDTH  data input, selected when {A,B,C} = 3'b010
//  D3    input   WIDTH  data input, selected when {A,B,C} = 3'b011
//  D4    input   WIDTH  data input, selected when {A,B,C} = 3'b100
//  D5    input   WIDTH  data input, selected when {A,B,C} = 3'b101
//  D6    input   WIDTH  data input, selected when {A,B,C} = 3'b110
//  D7    input   WIDTH  data input, selected when {A,B,C} = 3'b111
//  A     input   1      select MSB
//  B     input   1      select middle bit
//  C     input   1      select LSB
//  F_q   output  WIDTH  F registered on clk
// BEHAVIOUR
//  - Positional port order F, D0..D7, A, B, C is fixed. clk, rst and F_q are connected by name.
//  - F = D[{A,B,C}], zero latency, no clock dependence. F is unaffected by rst.
//  - Any change on a D input or a select bit propagates to F in the same delta/time step. No glitch filtering.
//  - F_q: asynchronous reset. While rst = 1, F_q = RESET_VAL immediately.
//  - F_q: on each rising clk edge with rst = 0, F_q <= F. F_q lags F by one cycle.
//  - Reset deassertion mid-stream: the first edge after rst falls captures the current F.
//  - Select containing X/Z: F = {WIDTH{1'bx}} in simulation. No latch is inferred; every code is covered
//    and the default branch assigns X.
//  - No internal state other than F_q. No handshake. Every select code is legal.
// STRUCTURE
//  - Shared package: SEL_W = 3 and NUM_IN = 8 constants, plus a sel_t typedef (logic [2:0]).
//  - Sub-module mux_2to1 (WIDTH param) is natural.
//  - Build as a 3-level tree of seven mux_2to1: C selects the first level, B the second, A the last.
//  - The F_q register is one always block in the top module.
// TESTING
//  1 D0..D7 = 1,0,1,0,1,0,1,0; step {A,B,C} 000..111 every 5 time units
//    -> F = 1,0,1,0,1,0,1,0 respectively.
//  2 One-hot walk: Dk = 1, all others 0; sweep all 8 selects
//    -> F = 1 only when {A,B,C} = k (64 checks).
//  3 Hold {A,B,C} = 101 and toggle D5 -> F follows D5 in the same time step;
//    toggling D0..D4, D6, D7 leaves F unchanged.
//  4 rst = 1 asynchronously, between clock edges -> F_q = RESET_VAL at once while F still tracks its input.
//    Release rst, then one edge -> F_q = F.
//  5 Clocked: change the select once per cycle -> F_q equals the previous cycle's F, i.e. one-cycle latency.
//  6 WIDTH = 8, Dk = 8'h10 + k, random selects -> F = 8'h10 + {A,B,C}.

Source files
------------

// File: rtl/mux_8to1_pkg.sv
// Shared constants and types for the 8:1 data selector.
package mux_8to1_pkg;

    localparam int SEL_W  = 3;
    localparam int NUM_IN = 8;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux_8to1_if.sv
// Bundle of the selector's data inputs, select code and both outputs.
// The source side drives d/sel; the selector side returns f and its registered copy f_q.
interface mux_8to1_if
    import mux_8to1_pkg::*;
#(
    parameter int WIDTH = 1
);

    logic [WIDTH-1:0] d [NUM_IN];
    sel_t             sel;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] f_q;

    modport master (output d, output sel, input f, input f_q);
    modport slave  (input d, input sel, output f, output f_q);

endinterface

// File: rtl/mux_8to1_mux_2to1.sv
// 2:1 leaf selector used to build the 8:1 tree.
// An unknown select yields all-X so a bad select code is visible in simulation.
module mux_2to1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    // Pick a when s is low, b when s is high, X otherwise.
    always_comb begin
        y = 'x;
        case (s)
            1'b0:    y = a;
            1'b1:    y = b;
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/mux_8to1.sv
// 8:1 data selector: F = D[{A,B,C}] combinationally, F_q is F registered on clk.
// Built as a three-level tree of 2:1 selectors; C steers the first level, B the
// second and A the last, so select bit weight matches tree depth.
module mux_8to1
    import mux_8to1_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    output logic [WIDTH-1:0] F,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic [WIDTH-1:0] D4,
    input  logic [WIDTH-1:0] D5,
    input  logic [WIDTH-1:0] D6,
    input  logic [WIDTH-1:0] D7,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] F_q
);

    sel_t             sel;
    logic [WIDTH-1:0] d_in [NUM_IN];
    logic [WIDTH-1:0] lvl1 [NUM_IN/2];
    logic [WIDTH-1:0] lvl2 [NUM_IN/4];

    assign sel = {A, B, C};

    assign d_in[0] = D0;
    assign d_in[1] = D1;
    assign d_in[2] = D2;
    assign d_in[3] = D3;
    assign d_in[4] = D4;
    assign d_in[5] = D5;
    assign d_in[6] = D6;
    assign d_in[7] = D7;

    for (genvar i = 0; i < NUM_IN/2; i++) begin : g_lvl1
        mux_2to1 #(.WIDTH(WIDTH)) u_mux (
            .a (d_in[2*i]),
            .b (d_in[2*i+1]),
            .s (sel[0]),
            .y (lvl1[i])
        );
    end

    for (genvar j = 0; j < NUM_IN/4; j++) begin : g_lvl2
        mux_2to1 #(.WIDTH(WIDTH)) u_mux (
            .a (lvl1[2*j]),
            .b (lvl1[2*j+1]),
            .s (sel[1]),
            .y (lvl2[j])
        );
    end

    mux_2to1 #(.WIDTH(WIDTH)) u_mux_root (
        .a (lvl2[0]),
        .b (lvl2[1]),
        .s (sel[SEL_W-1]),
        .y (F)
    );

    // Registered copy of F; reset only affects this register, never F.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            F_q <= RESET_VAL;
        end else begin
            F_q <= F;
        end
    end

endmodule

// File: tb/tb_mux_8to1.sv
// Directed bench for mux_8to1: a 1-bit and an 8-bit instance, scoreboard queue
// filled by the stimulus process and drained/compared by a separate monitor.
module tb_mux_8to1;
    import mux_8to1_pkg::*;

    localparam logic       RV1 = 1'b1;
    localparam logic [7:0] RV8 = 8'hA5;

    typedef struct {
        string      name;
        int         kind;
        logic [7:0] exp;
    } sb_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    sb_t  sb_q [$];
    event chk_ev;

    mux_8to1_if #(.WIDTH(1)) bus1 ();
    mux_8to1_if #(.WIDTH(8)) bus8 ();

    mux_8to1 #(.WIDTH(1), .RESET_VAL(RV1)) dut1 (
        .F (bus1.f), .D0(bus1.d[0]), .D1(bus1.d[1]), .D2(bus1.d[2]), .D3(bus1.d[3]),
        .D4(bus1.d[4]), .D5(bus1.d[5]), .D6(bus1.d[6]), .D7(bus1.d[7]),
        .A (bus1.sel[2]), .B(bus1.sel[1]), .C(bus1.sel[0]),
        .clk(clk), .rst(rst), .F_q(bus1.f_q)
    );

    mux_8to1 #(.WIDTH(8), .RESET_VAL(RV8)) dut8 (
        .F (bus8.f), .D0(bus8.d[0]), .D1(bus8.d[1]), .D2(bus8.d[2]), .D3(bus8.d[3]),
        .D4(bus8.d[4]), .D5(bus8.d[5]), .D6(bus8.d[6]), .D7(bus8.d[7]),
        .A (bus8.sel[2]), .B(bus8.sel[1]), .C(bus8.sel[0]),
        .clk(clk), .rst(rst), .F_q(bus8.f_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = F (1-bit), 1 = F_q (1-bit), 2 = F (8-bit), 3 = F_q (8-bit)
    task automatic expect_val(input string name, input int kind, input logic [7:0] exp);
        sb_q.push_back('{name, kind, exp});
        -> chk_ev;
        #1;
    endtask

    task automatic clear_d1();
        for (int k = 0; k < NUM_IN; k++) bus1.d[k] = 1'b0;
    endtask

    // Monitor: whenever stimulus posts expectations, sample the DUT and compare.
    initial begin
        sb_t        e;
        logic [7:0] act;
        checks = 0;
        errors = 0;
        forever begin
            @(chk_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                case (e.kind)
                    0:       act = {7'b0, bus1.f};
                    1:       act = {7'b0, bus1.f_q};
                    2:       act = bus8.f;
                    default: act = bus8.f_q;
                endcase
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] alt;
        logic [7:0] pat;
        sel_t       seq [8];
        sel_t       s;
        sel_t       prev;
        int         drain;

        alt = 8'h55;       // D0..D7 = 1,0,1,0,1,0,1,0
        pat = 8'b1011_0010; // D1, D4, D5, D7 high
        seq = '{3'd3, 3'd6, 3'd1, 3'd4, 3'd7, 3'd0, 3'd5, 3'd2};

        rst = 1'b1;
        clear_d1();
        bus1.sel = '0;
        for (int k = 0; k < NUM_IN; k++) bus8.d[k] = 8'h10 + 8'(k);
        bus8.sel = '0;

        // Reset state of both registered outputs
        #2;
        expect_val("reset_fq1", 1, {7'b0, RV1});
        expect_val("reset_fq8", 3, RV8);
        @(negedge clk);
        rst = 1'b0;

        // Alternating data, step select every 5 time units
        for (int k = 0; k < NUM_IN; k++) bus1.d[k] = alt[k];
        for (int i = 0; i < NUM_IN; i++) begin
            bus1.sel = sel_t'(i);
            #1;
            expect_val($sformatf("alt_sel%0d", i), 0, {7'b0, alt[i]});
            #3;
        end

        // One-hot walk
        for (int k = 0; k < NUM_IN; k++) begin
            clear_d1();
            bus1.d[k] = 1'b1;
            for (int i = 0; i < NUM_IN; i++) begin
                bus1.sel = sel_t'(i);
                #1;
                expect_val($sformatf("onehot_d%0d_sel%0d", k, i), 0, {7'b0, (i == k)});
            end
        end

        // Hold select 101, toggle D5 and the others
        clear_d1();
        bus1.sel = 3'b101;
        bus1.d[5] = 1'b1; #1; expect_val("hold_d5_hi", 0, 8'h01);
        bus1.d[5] = 1'b0; #1; expect_val("hold_d5_lo", 0, 8'h00);
        bus1.d[5] = 1'b1; #1; expect_val("hold_d5_hi2", 0, 8'h01);
        for (int k = 0; k < NUM_IN; k++) begin
            if (k != 5) begin
                bus1.d[k] = 1'b1; #1;
                expect_val($sformatf("hold_hi_other_d%0d", k), 0, 8'h01);
                bus1.d[k] = 1'b0;
            end
        end
        bus1.d[5] = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (k != 5) begin
                bus1.d[k] = 1'b1; #1;
                expect_val($sformatf("hold_lo_other_d%0d", k), 0, 8'h00);
                bus1.d[k] = 1'b0;
            end
        end

        // Unknown select bit drives X onto F
        bus1.sel = 3'b0x0;
        #1;
        expect_val("x_select", 0, {7'b0, 1'bx});

        // Asynchronous reset between edges
        @(negedge clk);
        clear_d1();
        bus1.sel = 3'd0;
        bus8.sel = 3'd6;
        @(posedge clk);
        #1;
        expect_val("pre_rst_fq1", 1, 8'h00);
        expect_val("pre_rst_fq8", 3, 8'h16);
        rst = 1'b1;
        #1;
        expect_val("rst_async_fq1", 1, {7'b0, RV1});
        expect_val("rst_async_fq8", 3, RV8);
        bus1.d[3] = 1'b1;
        bus1.sel = 3'd3;
        #1;
        expect_val("rst_f_tracks", 0, 8'h01);
        @(posedge clk);
        #1;
        expect_val("rst_held_fq1", 1, {7'b0, RV1});
        @(negedge clk);
        rst = 1'b0;
        bus1.d[3] = 1'b0;
        #1;
        expect_val("rel_fq1_still_rv", 1, {7'b0, RV1});
        @(posedge clk);
        #1;
        expect_val("rel_first_edge_fq1", 1, 8'h00);
        expect_val("rel_first_edge_fq8", 3, 8'h16);

        // Clocked: one select change per cycle, F_q lags by one cycle
        for (int k = 0; k < NUM_IN; k++) bus1.d[k] = pat[k];
        prev = 3'd0;
        for (int i = 0; i < NUM_IN; i++) begin
            @(negedge clk);
            s = seq[i];
            bus1.sel = s;
            #1;
            expect_val($sformatf("clk_f_%0d", i), 0, {7'b0, pat[s]});
            if (i > 0) expect_val($sformatf("clk_fq_lag_%0d", i), 1, {7'b0, pat[prev]});
            @(posedge clk);
            #1;
            expect_val($sformatf("clk_fq_%0d", i), 1, {7'b0, pat[s]});
            prev = s;
        end

        // 8-bit instance: all codes, then random selects
        for (int i = 0; i < NUM_IN; i++) begin
            bus8.sel = sel_t'(i);
            #1;
            expect_val($sformatf("w8_sel%0d", i), 2, 8'h10 + 8'(i));
        end
        for (int i = 0; i < 16; i++) begin
            s = sel_t'($urandom_range(0, 7));
            bus8.sel = s;
            #1;
            expect_val($sformatf("w8_rand%0d", i), 2, 8'h10 + 8'(s));
        end
        @(negedge clk);
        bus8.sel = 3'd7;
        @(posedge clk);
        #1;
        expect_val("w8_fq", 3, 8'h17);

        drain = 0;
        while (sb_q.size() > 0 && drain < 100) begin
            #1;
            drain++;
        end
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
